tick_divider_bank: RTL
======================

TICK_DIVIDER_BANK -- requirements
Module: tick_divider_bank

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the counter and divisor width per channel (minimum 2).
REQ-002 The block SHALL have parameter CHANNELS, default 4, giving the number of independent divider channels (minimum 1).
REQ-003 The block SHALL have port clk, input, 1 bit, the clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port clr, input, 1 bit, the reset, asynchronous and active-high.
REQ-005 The block SHALL have port en, input, CHANNELS bits, a per-channel count enable.
REQ-006 The block SHALL have port div, input, CHANNELS*WIDTH bits; channel i uses slice [i*WIDTH +: WIDTH], sampled every cycle.
REQ-007 The block SHALL have port mode, input, CHANNELS bits, per channel: 0 = periodic, 1 = one-shot.
REQ-008 The block SHALL have port start, input, CHANNELS bits, per-channel single-cycle launch/resync strobe.
REQ-009 The block SHALL have port stop, input, CHANNELS bits, per-channel abort strobe.
REQ-010 The block SHALL have port tick, output, CHANNELS bits, a registered one-cycle terminal-count pulse per channel.
REQ-011 The block SHALL have port busy, output, CHANNELS bits; 1 while the channel is in RUN.
REQ-012 The block SHALL have port state, output, CHANNELS*WIDTH bits, the registered counter value of each channel.

Function
REQ-013 Each channel SHALL run a two-state FSM, IDLE and RUN, fully independent of the other channels.
REQ-014 IDLE: cnt holds 0, tick is 0, and busy is 0; start=1 SHALL move the channel to RUN with cnt<=0 on the next edge.
REQ-015 In RUN with en=1 and cnt<div, the next edge SHALL set cnt<=cnt+1 and tick<=0.
REQ-016 In RUN with en=1 and cnt>=div, the next edge SHALL set cnt<=0 and tick<=1 for exactly one cycle.
REQ-017 The tick period SHALL therefore be div+1 enabled cycles; div=0 SHALL give tick on every enabled cycle.
REQ-018 In RUN with en=0, cnt SHALL freeze and tick SHALL be 0; en gaps stretch the period but do not lose count.
REQ-019 In periodic mode the channel SHALL remain in RUN after a tick.
REQ-020 In one-shot mode, on the edge that raises tick, the channel SHALL go to IDLE; busy SHALL fall in the same cycle tick is high.
REQ-021 start=1 in RUN SHALL resync the channel: cnt<=0, tick<=0, it stays in RUN, and any terminal count that edge is suppressed.
REQ-022 stop=1 SHALL force IDLE with cnt<=0 and tick<=0 on the next edge, in either state.
REQ-023 stop SHALL have priority over start; start SHALL have priority over counting.
REQ-024 If div is lowered below the current cnt, the >= compare SHALL terminate the count on the next enabled edge, with no wrap through 2^WIDTH.
REQ-025 cnt SHALL never exceed the maximum div value (2^WIDTH-1); no arithmetic overflow SHALL be possible.
REQ-026 mode SHALL be sampled on each edge; a change mid-run SHALL take effect at the next terminal count.
REQ-027 All outputs SHALL be registered, with no combinational path from any input to tick, busy or state.

Reset
REQ-028 clr=1 SHALL immediately, without waiting for clk, force every channel to IDLE with cnt=0, tick=0 and busy=0.
REQ-029 While clr=1, all inputs SHALL be ignored.
REQ-030 After clr falls, the first edge SHALL process inputs normally; clr asserted mid-RUN SHALL discard the count in progress.

Verification
REQ-031 Periodic: ch0 with div=3, mode=0, en=1, start pulsed -> tick[0] high one cycle every 4 clocks; state cycles 0,1,2,3,0.
REQ-032 One-shot plus en gaps: div=2, mode=1, en toggling 1,0,1,1 -> single tick after 3 enabled edges; busy falls with tick; then IDLE and state=0.
REQ-033 Priority: start and stop high together in RUN -> IDLE, state=0, no tick; a later start alone during RUN at cnt=5, div=7 -> cnt=0 with no tick.
REQ-034 div shrink: RUN at cnt=6, div changed 9->2 -> tick on the next enabled edge, then period of 3.
REQ-035 Async reset: clr pulsed between clock edges mid-count -> outputs go to 0 before the next edge, and all channels are in IDLE after release.
REQ-036 Independence and boundaries: CHANNELS=4 with div=0, 1, 255, 5 all periodic -> tick rates of every cycle, every 2, every 256 and every 6 cycles, with no cross-channel interaction.

Source files
------------

// File: rtl/tick_divider_bank.sv
// Bank of independent programmable tick dividers, one two-state FSM per channel.
// Each channel emits a registered one-cycle tick every div+1 enabled cycles.
module tick_divider_bank #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic                         clk,
  input  logic                         clr,
  input  logic [CHANNELS-1:0]          en,
  input  logic [CHANNELS*WIDTH-1:0]    div,
  input  logic [CHANNELS-1:0]          mode,
  input  logic [CHANNELS-1:0]          start,
  input  logic [CHANNELS-1:0]          stop,
  output logic [CHANNELS-1:0]          tick,
  output logic [CHANNELS-1:0]          busy,
  output logic [CHANNELS*WIDTH-1:0]    state
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} st_t;

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    st_t              st_q, st_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_c;
    logic             tick_q, tick_d;

    assign div_c = div[ch*WIDTH +: WIDTH];

    always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
        st_q   <= IDLE;
        cnt_q  <= '0;
        tick_q <= 1'b0;
      end else begin
        st_q   <= st_d;
        cnt_q  <= cnt_d;
        tick_q <= tick_d;
      end
    end

    // stop beats start, start beats counting; >= compare absorbs a shrinking div
    always_comb begin
      st_d   = st_q;
      cnt_d  = cnt_q;
      tick_d = 1'b0;
      if (stop[ch]) begin
        st_d  = IDLE;
        cnt_d = '0;
      end else if (start[ch]) begin
        st_d  = RUN;
        cnt_d = '0;
      end else begin
        case (st_q)
          RUN: begin
            if (en[ch]) begin
              if (cnt_q >= div_c) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                if (mode[ch]) st_d = IDLE;
              end else begin
                cnt_d = cnt_q + 1'b1;
              end
            end
          end
          default: begin
            st_d  = IDLE;
            cnt_d = '0;
          end
        endcase
      end
    end

    assign tick[ch]                   = tick_q;
    assign busy[ch]                   = (st_q == RUN);
    assign state[ch*WIDTH +: WIDTH]   = cnt_q;
  end

endmodule
